// File: rtl/data_mem.sv
// data_mem: byte-addressable data memory for the MEM stage.
// Combinational loads, clocked stores, sticky alignment-fault capture.
module data_mem #(
   parameter int DEPTH_LOG2 = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] addr,
   input  logic [31:0] wd,
   input  logic        MemWrite,
   input  logic        MemRead,
   input  logic [2:0]  MemOp,
   output logic [31:0] dm_out,
   output logic        AddrErr,
   output logic [31:0] ErrAddr,
   output logic [7:0]  ErrCnt
);

   localparam int DEPTH = 1 << DEPTH_LOG2;

   localparam logic [2:0] OP_W  = 3'b000;
   localparam logic [2:0] OP_HS = 3'b001;
   localparam logic [2:0] OP_HU = 3'b010;
   localparam logic [2:0] OP_BS = 3'b011;
   localparam logic [2:0] OP_BU = 3'b100;

   logic [31:0]           mem_q [DEPTH];
   logic [DEPTH_LOG2-1:0] idx;
   logic [31:0]           rword;
   logic [15:0]           rhalf;
   logic [7:0]            rbyte;
   logic [31:0]           wdata;
   logic [31:0]           word_d;
   logic [31:0]           load_val;
   logic [3:0]            be;
   logic                  legal;
   logic                  access;
   logic                  fault;
   logic                  wr_en;

   logic                  err_q,   err_d;
   logic [31:0]           eaddr_q, eaddr_d;
   logic [7:0]            ecnt_q,  ecnt_d;

   // upper address bits fold onto the array (aliasing)
   assign idx   = addr[DEPTH_LOG2+1:2];
   assign rword = mem_q[idx];
   assign rhalf = addr[1] ? rword[31:16] : rword[15:0];
   assign rbyte = rword[{addr[1:0], 3'b000} +: 8];

   // alignment check, lane enables and lane-replicated store data
   always_comb begin
      legal = 1'b0;
      be    = 4'b0000;
      wdata = wd;
      case (MemOp)
         OP_W: begin
            legal = (addr[1:0] == 2'b00);
            be    = 4'b1111;
         end
         OP_HS, OP_HU: begin
            legal = ~addr[0];
            be    = addr[1] ? 4'b1100 : 4'b0011;
            wdata = {2{wd[15:0]}};
         end
         OP_BS, OP_BU: begin
            legal = 1'b1;
            be    = 4'b0001 << addr[1:0];
            wdata = {4{wd[7:0]}};
         end
         default: legal = 1'b0;
      endcase
   end

   assign access = MemRead | MemWrite;
   assign fault  = access & ~legal;
   assign wr_en  = MemWrite & legal;

   // merge enabled store lanes into the current word
   always_comb begin
      word_d = rword;
      for (int l = 0; l < 4; l++) begin
         if (be[l]) word_d[8*l +: 8] = wdata[8*l +: 8];
      end
   end

   // load extension by access type
   always_comb begin
      load_val = '0;
      case (MemOp)
         OP_W:    load_val = rword;
         OP_HS:   load_val = {{16{rhalf[15]}}, rhalf};
         OP_HU:   load_val = {16'h0000, rhalf};
         OP_BS:   load_val = {{24{rbyte[7]}}, rbyte};
         OP_BU:   load_val = {24'h000000, rbyte};
         default: load_val = '0;
      endcase
   end

   assign dm_out = (MemRead && legal) ? load_val : '0;

   // storage array, wiped by reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (wr_en) begin
         mem_q[idx] <= word_d;
      end
   end

   // fault bookkeeping: sticky flag, first address, saturating count
   always_comb begin
      err_d   = err_q;
      eaddr_d = eaddr_q;
      ecnt_d  = ecnt_q;
      if (fault) begin
         err_d = 1'b1;
         if (!err_q) eaddr_d = addr;
         if (ecnt_q != 8'hFF) ecnt_d = ecnt_q + 8'd1;
      end
   end

   // error state registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_q   <= 1'b0;
         eaddr_q <= '0;
         ecnt_q  <= '0;
      end else begin
         err_q   <= err_d;
         eaddr_q <= eaddr_d;
         ecnt_q  <= ecnt_d;
      end
   end

   assign AddrErr = err_q;
   assign ErrAddr = eaddr_q;
   assign ErrCnt  = ecnt_q;

endmodule

// File: tb/tb_data_mem.sv
// tb_data_mem: directed bench for data_mem with a byte-level
// reference memory checked every cycle, plus literal spot checks.
module tb_data_mem;

   logic        clk;
   logic        rst_n;
   logic [31:0] addr;
   logic [31:0] wd;
   logic        MemWrite;
   logic        MemRead;
   logic [2:0]  MemOp;
   logic [31:0] dm_out;
   logic        AddrErr;
   logic [31:0] ErrAddr;
   logic [7:0]  ErrCnt;

   int checks;
   int errors;

   logic [7:0]  mb [1024];
   logic        m_err;
   logic [31:0] m_eaddr;
   int          m_cnt;

   data_mem #(.DEPTH_LOG2(8)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .addr     (addr),
      .wd       (wd),
      .MemWrite (MemWrite),
      .MemRead  (MemRead),
      .MemOp    (MemOp),
      .dm_out   (dm_out),
      .AddrErr  (AddrErr),
      .ErrAddr  (ErrAddr),
      .ErrCnt   (ErrCnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic bit is_legal(input logic [2:0] op, input logic [31:0] a);
      case (op)
         3'd0:       return (a % 4) == 0;
         3'd1, 3'd2: return (a % 2) == 0;
         3'd3, 3'd4: return 1'b1;
         default:    return 1'b0;
      endcase
   endfunction

   function automatic logic [31:0] exp_load(input logic [2:0] op,
                                            input logic [31:0] a,
                                            input logic rd);
      int b;
      logic [7:0] b0, b1, b2, b3;
      if (!rd || !is_legal(op, a)) return 32'h0;
      b  = int'(a % 1024);
      b0 = mb[b];
      b1 = mb[(b + 1) % 1024];
      b2 = mb[(b + 2) % 1024];
      b3 = mb[(b + 3) % 1024];
      case (op)
         3'd0:    return {b3, b2, b1, b0};
         3'd1:    return {{16{b1[7]}}, b1, b0};
         3'd2:    return {16'h0, b1, b0};
         3'd3:    return {{24{b0[7]}}, b0};
         default: return {24'h0, b0};
      endcase
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 1024; i++) mb[i] = 8'h00;
      m_err   = 1'b0;
      m_eaddr = 32'h0;
      m_cnt   = 0;
   endtask

   task automatic model_edge();
      int b;
      int n;
      if (!(MemRead || MemWrite)) return;
      if (!is_legal(MemOp, addr)) begin
         if (!m_err) m_eaddr = addr;
         m_err = 1'b1;
         if (m_cnt < 255) m_cnt++;
         return;
      end
      if (!MemWrite) return;
      b = int'(addr % 1024);
      n = (MemOp == 3'd0) ? 4 : (MemOp <= 3'd2) ? 2 : 1;
      for (int k = 0; k < n; k++) mb[(b + k) % 1024] = wd[8*k +: 8];
   endtask

   task automatic drive(input logic w, input logic r, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] d);
      MemWrite = w;
      MemRead  = r;
      MemOp    = op;
      addr     = a;
      wd       = d;
   endtask

   task automatic sample();
      @(negedge clk);
      chk("dm_out", dm_out, exp_load(MemOp, addr, MemRead));
      chk("AddrErr", {31'h0, AddrErr}, {31'h0, m_err});
      chk("ErrAddr", ErrAddr, m_eaddr);
      chk("ErrCnt", {24'h0, ErrCnt}, m_cnt);
   endtask

   task automatic commit();
      @(posedge clk);
      if (rst_n) model_edge();
      #1;
   endtask

   task automatic cyc(input logic w, input logic r, input logic [2:0] op,
                      input logic [31:0] a, input logic [31:0] d);
      drive(w, r, op, a, d);
      sample();
      commit();
   endtask

   task automatic ld(input logic [2:0] op, input logic [31:0] a,
                     input string nm, input logic [31:0] exp);
      drive(1'b0, 1'b1, op, a, 32'h0);
      sample();
      chk(nm, dm_out, exp);
      commit();
   endtask

   initial begin
      checks = 0;
      errors = 0;
      model_reset();
      drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #1;
      chk("rst AddrErr", {31'h0, AddrErr}, 32'h0);
      chk("rst ErrCnt", {24'h0, ErrCnt}, 32'h0);
      chk("rst ErrAddr", ErrAddr, 32'h0);
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      #1;

      // word round trip and alias
      cyc(1'b1, 1'b0, 3'd0, 32'h10, 32'hDEADBEEF);
      ld(3'd0, 32'h10,  "lw 0x10",  32'hDEADBEEF);
      ld(3'd0, 32'h410, "lw alias", 32'hDEADBEEF);

      // sub-word store and loads
      cyc(1'b1, 1'b0, 3'd0, 32'h10, 32'h11223344);
      cyc(1'b1, 1'b0, 3'd3, 32'h13, 32'h00000080);
      ld(3'd0, 32'h10, "lw merged", 32'h80223344);
      ld(3'd3, 32'h13, "lb 0x13",   32'hFFFFFF80);
      ld(3'd4, 32'h13, "lbu 0x13",  32'h00000080);
      ld(3'd1, 32'h12, "lh 0x12",   32'hFFFF8022);
      ld(3'd2, 32'h12, "lhu 0x12",  32'h00008022);
      cyc(1'b1, 1'b0, 3'd2, 32'h16, 32'h0000BEEF);
      ld(3'd0, 32'h14, "sh upper", 32'hBEEF0000);

      // read during write
      cyc(1'b1, 1'b0, 3'd0, 32'h10, 32'h1);
      drive(1'b1, 1'b1, 3'd0, 32'h10, 32'h2);
      sample();
      chk("rdw old", dm_out, 32'h1);
      commit();
      ld(3'd0, 32'h10, "rdw new", 32'h2);

      // misalignment faults
      cyc(1'b1, 1'b0, 3'd0, 32'h22, 32'hAAAAAAAA);
      chk("mis AddrErr", {31'h0, AddrErr}, 32'h1);
      chk("mis ErrAddr", ErrAddr, 32'h22);
      chk("mis ErrCnt", {24'h0, ErrCnt}, 32'h1);
      ld(3'd0, 32'h20, "mis mem", 32'h0);
      ld(3'd1, 32'h31, "lh odd", 32'h0);
      chk("mis2 ErrAddr", ErrAddr, 32'h22);
      chk("mis2 ErrCnt", {24'h0, ErrCnt}, 32'h2);
      ld(3'd6, 32'h10, "rsv load", 32'h0);
      chk("rsv ErrCnt", {24'h0, ErrCnt}, 32'h3);

      // idle cycles ignore addr and op
      cyc(1'b0, 1'b0, 3'd7, 32'h33, 32'hFFFFFFFF);
      cyc(1'b0, 1'b0, 3'd0, 32'h21, 32'h12345678);
      chk("idle ErrCnt", {24'h0, ErrCnt}, 32'h3);

      // mixed traffic against the model
      for (int i = 0; i < 200; i++) begin
         cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             3'($urandom_range(0, 7)), 32'($urandom_range(0, 2047)),
             $urandom);
      end

      // asynchronous reset between edges, store under reset dropped
      cyc(1'b1, 1'b0, 3'd0, 32'h40, 32'hCAFEF00D);
      drive(1'b1, 1'b1, 3'd0, 32'h40, 32'h55555555);
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      chk("ar dm_out", dm_out, 32'h0);
      chk("ar AddrErr", {31'h0, AddrErr}, 32'h0);
      chk("ar ErrAddr", ErrAddr, 32'h0);
      chk("ar ErrCnt", {24'h0, ErrCnt}, 32'h0);
      sample();
      commit();
      rst_n = 1'b1;
      ld(3'd0, 32'h40, "ar store lost", 32'h0);
      ld(3'd0, 32'h10, "ar wiped", 32'h0);

      // saturating error counter
      for (int i = 0; i < 300; i++) begin
         cyc(1'b0, 1'b1, 3'd0, 32'h101 + 32'(i * 4), 32'h0);
      end
      chk("sat ErrCnt", {24'h0, ErrCnt}, 32'd255);
      chk("sat AddrErr", {31'h0, AddrErr}, 32'h1);
      chk("sat ErrAddr", ErrAddr, 32'h101);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/data_mem.md
DATA_MEM -- requirements
Module: data_mem

Interface
REQ-001 Parameter DEPTH_LOG2, default 8, log2 of word count (256 words = 1 KiB).
REQ-002 clk  input  1  rising-edge clock, sole clock domain.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 addr  input  32  byte address from the EX/MEM ALU result.
REQ-005 wd  input  32  store data (rt register value).
REQ-006 MemWrite  input  1  store enable.
REQ-007 MemRead  input  1  load enable.
REQ-008 MemOp  input  3  access type: 000 word, 001 half signed, 010 half unsigned, 011 byte signed, 100 byte unsigned, 101-111 reserved.
REQ-009 dm_out  output  32  load result, consumed by the MEM/WB write-back select.
REQ-010 AddrErr  output  1  registered sticky misalignment/illegal-access flag.
REQ-011 ErrAddr  output  32  registered address of the first faulting access.
REQ-012 ErrCnt  output  8  registered saturating count of faulting accesses.

Function
REQ-013 Storage SHALL be 2^DEPTH_LOG2 words of 32 bits, little-endian; word index = addr[DEPTH_LOG2+1:2]; higher address bits ignored (aliasing wrap-around).
REQ-014 Alignment: word access legal only if addr[1:0]=00; halfword only if addr[0]=0; byte always legal; reserved MemOp always illegal.
REQ-015 An access is faulting when (MemRead or MemWrite) is high and the access is illegal per REQ-014.
REQ-016 Store SHALL update memory on the rising clk edge when MemWrite=1 and the access is legal; word writes all 4 lanes, halfword writes lanes addr[1]*2 and +1 from wd[15:0], byte writes lane addr[1:0] from wd[7:0]; other lanes unchanged.
REQ-017 Faulting store SHALL leave memory unchanged.
REQ-018 Load SHALL be combinational (zero-cycle latency within the MEM stage): dm_out reflects current array contents for the addressed word.
REQ-019 Load formatting: word = full word; half signed/unsigned = selected 16 bits sign/zero extended; byte signed/unsigned = selected 8 bits sign/zero extended.
REQ-020 dm_out SHALL be 0 when MemRead=0 or the load is faulting.
REQ-021 Simultaneous MemRead and MemWrite, same cycle: store performed at edge; dm_out in that cycle returns pre-write data.
REQ-022 Read of an address written in the previous cycle SHALL return the new data.
REQ-023 On the edge ending a faulting cycle: AddrErr set to 1; if AddrErr was 0, ErrAddr captures addr; ErrCnt increments, saturating at 255.
REQ-024 AddrErr and ErrAddr SHALL hold (sticky) until reset; non-faulting cycles leave all error outputs unchanged.
REQ-025 MemRead=MemWrite=0 SHALL be idle: no memory change, no error update regardless of addr/MemOp.

Reset
REQ-026 rst_n low SHALL immediately, without waiting for clk, clear every memory word to 0, AddrErr to 0, ErrAddr to 0, ErrCnt to 0; dm_out consequently reads 0.
REQ-027 Store coincident with reset assertion SHALL be discarded; first store accepted on the first rising edge with rst_n high.
REQ-028 Reset asserted mid-sequence SHALL discard all prior contents and error history.

Verification
REQ-029 Word round-trip: store 0xDEADBEEF at 0x10, next cycle load word 0x10 -> dm_out=0xDEADBEEF; load word 0x410 (alias, DEPTH_LOG2=8) -> 0xDEADBEEF.
REQ-030 Sub-word: store byte 0x80 at 0x13 over word 0x11223344 at 0x10 -> word 0x80223344; lb 0x13 -> 0xFFFFFF80; lbu 0x13 -> 0x00000080; lh 0x12 -> 0xFFFF8022; lhu 0x12 -> 0x00008022.
REQ-031 Misalignment: store word 0xAAAAAAAA at 0x22 -> memory unchanged, AddrErr=1, ErrAddr=0x22, ErrCnt=1; then lh at 0x31 -> dm_out=0, ErrAddr stays 0x22, ErrCnt=2; reserved MemOp 110 load -> ErrCnt=3.
REQ-032 Read-during-write: word 0x10=0x1, assert MemRead+MemWrite word 0x10 wd=0x2 -> dm_out=0x1 that cycle, 0x2 next cycle.
REQ-033 Saturation: 300 consecutive faulting accesses -> ErrCnt=255, AddrErr=1, ErrAddr=first address.
REQ-034 Async reset: after writes and errors, pulse rst_n low between clk edges -> all outputs and loaded words read 0 before next edge; store during reset not retained.
